vc_arbitro_wrr: RTL

- Weighted round-robin arbiter between the two virtual-channel FIFOs (VC0, VC1) of the transaction-layer datapath.
- Pops one word per cycle from the granted VC and routes it to destination FIFO D0 or D1 according to the word's destination bit.
- Respects D0/D1 almost-full backpressure, derived from the Ds threshold.
- Sits between the VC FIFOs and the D FIFOs. It is gated by the main FSM's active state.

---
 rtl/vc_arbitro_wrr.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vc_arbitro_wrr.sv
// Weighted round-robin arbiter from the two virtual-channel FIFOs to the D0/D1 FIFOs.
// Pops are combinational (FWFT heads); the popped word is pushed one cycle later.
module vc_arbitro_wrr #(
    parameter int data_width = 6,
    parameter int DEST_BIT   = 4,
    parameter int VC0_WEIGHT = 3,
    parameter int VC1_WEIGHT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [data_width-1:0] vc0_data,
    input  logic [data_width-1:0] vc1_data,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    output logic                  vc0_pop,
    output logic                  vc1_pop,
    output logic                  d0_push,
    output logic                  d1_push,
    output logic [data_width-1:0] data_out,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } serve_t;

    localparam logic [3:0] W0 = 4'(VC0_WEIGHT);
    localparam logic [3:0] W1 = 4'(VC1_WEIGHT);

    serve_t     cur, cur_next;
    logic [3:0] cnt, cnt_next;
    logic       pick0, pick1;
    logic       vc0_dest, vc1_dest;
    logic       elig0, elig1;

    assign vc0_dest = vc0_data[DEST_BIT];
    assign vc1_dest = vc1_data[DEST_BIT];

    // A head is only eligible if its own destination has room, so a blocked
    // head on one VC never stalls the other VC.
    assign elig0 = enable & reset & ~vc0_empty & ~(vc0_dest ? d1_almost_full : d0_almost_full);
    assign elig1 = enable & reset & ~vc1_empty & ~(vc1_dest ? d1_almost_full : d0_almost_full);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        pick0    = 1'b0;
        pick1    = 1'b0;
        cur_next = IDLE;
        cnt_next = 4'd0;
        case (cur)
            SERVE0: begin
                if (elig0 && cnt < W0) begin
                    pick0    = 1'b1;
                    cur_next = SERVE0;
                    cnt_next = cnt + 4'd1;
                end else if (elig1) begin
                    pick1    = 1'b1;
                    cur_next = SERVE1;
                    cnt_next = 4'd1;
                end else if (elig0) begin
                    pick0    = 1'b1;
                    cur_next = SERVE0;
                    cnt_next = 4'd1;
                end
            end
            SERVE1: begin
                if (elig1 && cnt < W1) begin
                    pick1    = 1'b1;
                    cur_next = SERVE1;
                    cnt_next = cnt + 4'd1;
                end else if (elig0) begin
                    pick0    = 1'b1;
                    cur_next = SERVE0;
                    cnt_next = 4'd1;
                end else if (elig1) begin
                    pick1    = 1'b1;
                    cur_next = SERVE1;
                    cnt_next = 4'd1;
                end
            end
            default: begin
                if (elig0) begin
                    pick0    = 1'b1;
                    cur_next = SERVE0;
                    cnt_next = 4'd1;
                end else if (elig1) begin
                    pick1    = 1'b1;
                    cur_next = SERVE1;
                    cnt_next = 4'd1;
                end
            end
        endcase
    end

    assign vc0_pop = pick0;
    assign vc1_pop = pick1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= IDLE;
            cnt <= 4'd0;
        end else begin
            cur <= cur_next;
            cnt <= cnt_next;
        end
    end

    // Output stage: the reset clears any word popped in the previous cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d0_push  <= 1'b0;
            d1_push  <= 1'b0;
            grant    <= 2'b00;
            data_out <= '0;
        end else begin
            d0_push <= (pick0 & ~vc0_dest) | (pick1 & ~vc1_dest);
            d1_push <= (pick0 &  vc0_dest) | (pick1 &  vc1_dest);
            grant   <= {pick1, pick0};
            if (pick0) begin
                data_out <= vc0_data;
            end else if (pick1) begin
                data_out <= vc1_data;
            end
        end
    end

endmodule
